demux1_4_stream: RTL and testbench

Stream demultiplexer: one valid/ready input stream fanned out to four valid/ready output channels, each backed by a one-entry output register. A 2-bit select routes each packet. The select is latched on a packet's first beat and held until its `in_last` beat, so multi-beat packets never split across channels. The block feeds the 4:1 multiplexers' input side, distributing a shared source to per-lane consumers.

---
 rtl/demux1_4_stream_pkg.sv | 10 +
 rtl/demux1_4_stream_if.sv | 26 ++
 rtl/demux1_4_stream_out_slot.sv | 47 ++++
 rtl/demux1_4_stream.sv | 79 +++++++
 tb/tb_demux1_4_stream.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/demux1_4_stream_pkg.sv
// Shared constants and state encoding for the 1:4 stream demultiplexer.
package demux_pkg;
  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_t;
endpackage

// File: rtl/demux1_4_stream_if.sv
// Input stream plus the four output channels of the demultiplexer.
interface demux1_4_stream_if #(parameter int WIDTH = 8);
  import demux_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_last;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_last;
  logic                   busy;
  logic [SEL_W-1:0]       lock_sel;

  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, lock_sel
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, lock_sel
  );
endinterface

// File: rtl/demux1_4_stream_out_slot.sv
// One-entry output register slice; a load in the same cycle as a drain replaces the beat without a bubble.
module out_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             d_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q,
  output logic             q_last
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = d;
      last_d  = d_last;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid  = valid_q;
  assign q      = data_q;
  assign q_last = last_q;
endmodule

// File: rtl/demux1_4_stream.sv
// 1:4 stream demultiplexer; the channel is latched on a packet's first beat and held until its last beat.
module demux1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  demux1_4_stream_if.slave bus
);
  demux_state_t                 state_q, state_d;
  logic [SEL_W-1:0]             lock_sel_q, lock_sel_d;
  logic                         busy_q;
  logic [SEL_W-1:0]             target;
  logic                         in_ready;
  logic                         accept;
  logic [N_OUT-1:0]             load;
  logic [N_OUT-1:0]             slot_vld;
  logic [N_OUT-1:0]             slot_last;
  logic [N_OUT-1:0][WIDTH-1:0]  slot_q;

  // Ready looks only at the target slot, so a stalled sibling never blocks the input.
  always_comb begin
    target     = (state_q == LOCKED) ? lock_sel_q : bus.in_sel;
    in_ready   = !slot_vld[target] || bus.out_ready[target];
    accept     = bus.in_valid && in_ready;
    load       = '0;
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (accept) begin
      load[target] = 1'b1;
      case (state_q)
        IDLE: begin
          if (!bus.in_last) begin
            state_d    = LOCKED;
            lock_sel_d = bus.in_sel;
          end
        end
        LOCKED: begin
          if (bus.in_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      busy_q     <= (state_d == LOCKED);
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst    (rst),
      .load   (load[k]),
      .d      (bus.in_data),
      .d_last (bus.in_last),
      .ready  (bus.out_ready[k]),
      .valid  (slot_vld[k]),
      .q      (slot_q[k]),
      .q_last (slot_last[k])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = slot_vld;
  assign bus.out_data  = slot_q;
  assign bus.out_last  = slot_last;
  assign bus.busy      = busy_q;
  assign bus.lock_sel  = lock_sel_q;
endmodule

// File: tb/tb_demux1_4_stream.sv
// Scoreboard bench for demux1_4_stream: per-channel expected queues built from packet routing rules.
module tb_demux1_4_stream;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  demux1_4_stream_if #(.WIDTH(8)) bus ();

  demux1_4_stream #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: each channel is a FIFO of {last,data}; the packet's channel comes from its first beat.
  logic [8:0] exp_q [4][$];
  bit         in_pkt = 1'b0;
  logic [1:0] pkt_dest = 2'd0;
  logic [1:0] m_dst;
  logic       m_er;

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) exp_q[k].delete();
      in_pkt = 1'b0;
    end else begin
      m_dst = in_pkt ? pkt_dest : bus.in_sel;
      m_er  = (exp_q[m_dst].size() == 0) || bus.out_ready[m_dst];
      chk("in_ready", bus.in_ready, m_er);
      chk("busy", bus.busy, in_pkt);
      if (in_pkt) chk("lock_sel", bus.lock_sel, pkt_dest);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), bus.out_valid[k], exp_q[k].size() != 0);
        if (bus.out_valid[k] && exp_q[k].size() != 0) begin
          chk($sformatf("beat ch%0d", k), {bus.out_last[k], bus.out_data[k*8 +: 8]}, exp_q[k][0]);
          if (bus.out_ready[k]) void'(exp_q[k].pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q[m_dst].push_back({bus.in_last, bus.in_data});
        if (!in_pkt && !bus.in_last) begin
          in_pkt   = 1'b1;
          pkt_dest = bus.in_sel;
        end else if (in_pkt && bus.in_last) begin
          in_pkt = 1'b0;
        end
      end
    end
  end

  task automatic rand_ready();
    for (int k = 0; k < 4; k++) bus.out_ready[k] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) rand_ready();
    end
  endtask

  // Presents one beat and holds it until accepted; waits = stalled cycles.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l, output int waits);
    int  n = 0;
    bit  done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_last  = l;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      else begin
        n++;
        if (n > 1000) begin
          checks++;
          errors++;
          $display("FAIL accept timeout: got no accept after %0d cycles, expected accept", n);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (rand_rdy) rand_ready();
    end
    bus.in_valid = 1'b0;
    waits = n;
  endtask

  task automatic check_reset_outputs();
    chk("rst out_valid", bus.out_valid, 4'h0);
    chk("rst out_data", bus.out_data, 32'h0);
    chk("rst out_last", bus.out_last, 4'h0);
    chk("rst busy", bus.busy, 1'b0);
    chk("rst lock_sel", bus.lock_sel, 2'd0);
  endtask

  initial begin
    int w;
    int beats;
    int len;
    logic [1:0] s;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_sel    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 4'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-packet: open a packet to ch3, reset, then a single beat to ch1.
    bus.out_ready = 4'h0;
    send(8'h33, 2'd3, 1'b0, w);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 4'hF;
    send(8'h11, 2'd1, 1'b1, w);
    @(negedge clk);
    chk("post-reset ch1 valid", bus.out_valid, 4'b0010);
    chk("post-reset ch1 data", bus.out_data[15:8], 8'h11);
    @(posedge clk); #1;

    // Single-beat packets, one per cycle.
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), 2'(i), 1'b1, w);
      chk("single-beat stall", w, 0);
    end
    idle(2);

    // Locked 3-beat packet; in_sel moves away mid-packet.
    send(8'h01, 2'd2, 1'b0, w);
    chk("lock busy", bus.busy, 1'b1);
    send(8'h02, 2'd0, 1'b0, w);
    send(8'h03, 2'd0, 1'b1, w);
    chk("unlock busy", bus.busy, 1'b0);
    idle(2);

    // Backpressure on ch3 while other channels drain.
    bus.out_ready = 4'b0111;
    send(8'hB0, 2'd0, 1'b1, w);
    send(8'hB3, 2'd3, 1'b1, w);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hB4;
    bus.in_sel   = 2'd3;
    bus.in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp in_ready", bus.in_ready, 1'b0);
      chk("bp ch3 hold", bus.out_data[31:24], 8'hB3);
      @(posedge clk); #1;
    end
    bus.out_ready = 4'hF;
    @(negedge clk);
    chk("bp release in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    idle(2);

    // Independence: ch0 stalled and full, ch1 streams at full rate.
    bus.out_ready = 4'b1110;
    send(8'hC0, 2'd0, 1'b1, w);
    for (int i = 0; i < 4; i++) begin
      send(8'hD0 + 8'(i), 2'd1, i == 3, w);
      chk("indep stall", w, 0);
      chk("indep ch0 hold", bus.out_data[7:0], 8'hC0);
    end
    bus.out_ready = 4'hF;
    idle(2);

    // Random packets with random consumer readiness.
    rand_rdy = 1'b1;
    beats = 0;
    while (beats < 10000) begin
      len = $urandom_range(1, 4);
      s   = 2'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) begin
        send(8'($urandom), (i == 0) ? s : 2'($urandom_range(0, 3)), i == len - 1, w);
        beats++;
        if ($urandom_range(0, 7) == 0) idle(1);
      end
    end
    rand_rdy = 1'b0;
    bus.out_ready = 4'hF;
    idle(4);
    for (int k = 0; k < 4; k++) chk($sformatf("drain ch%0d leftover", k), exp_q[k].size(), 0);
    chk("final out_valid", bus.out_valid, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
